// File: rtl/apb_event_sink.sv
// rtl/apb_event_sink.sv - APB completer that counts event writes and serves counter reads
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   apb_psel_i            APB select
//   apb_penable_i         APB enable (ACCESS phase)
//   apb_paddr_i           APB address, latched in SETUP
//   apb_pwrite_i          1 = write, 0 = read, latched in SETUP
//   apb_pwdata_i          write data, latched in SETUP
//   apb_pready_o          single-cycle completion pulse
//   apb_prdata_o          read data, non-zero only in the completing cycle of a read
//   cnt_a_o/b_o/c_o       saturating write counts for events A, B, C
//   bad_addr_cnt_o        saturating count of writes to unmapped addresses
//   last_wdata_o          write data of the most recent committed A/B/C write
module apb_event_sink #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned CNT_W       = 16,
    parameter logic [31:0] ADDR_A      = 32'h0000_0000,
    parameter logic [31:0] ADDR_B      = 32'h0000_0004,
    parameter logic [31:0] ADDR_C      = 32'h0000_0008,
    parameter logic [31:0] ADDR_CLR    = 32'h0000_000C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             apb_psel_i,
    input  logic             apb_penable_i,
    input  logic [31:0]      apb_paddr_i,
    input  logic             apb_pwrite_i,
    input  logic [31:0]      apb_pwdata_i,
    output logic             apb_pready_o,
    output logic [31:0]      apb_prdata_o,
    output logic [CNT_W-1:0] cnt_a_o,
    output logic [CNT_W-1:0] cnt_b_o,
    output logic [CNT_W-1:0] cnt_c_o,
    output logic [CNT_W-1:0] bad_addr_cnt_o,
    output logic [31:0]      last_wdata_o
);

    localparam int WC_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WC_W-1:0]   wait_cnt;
    logic [WC_W-1:0]   wait_cnt_nxt;
    logic              latch;
    logic              commit;

    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              write_q;

    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [CNT_W-1:0]  cnt_c;
    logic [CNT_W-1:0]  cnt_bad;
    logic [31:0]       last_wdata;

    logic              hit_a;
    logic              hit_b;
    logic              hit_c;
    logic              hit_clr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next-state and transfer control. A SETUP seen while already in ACCESS
    // restarts the transfer; psel dropping in ACCESS abandons it silently.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        latch        = 1'b0;
        commit       = 1'b0;
        case (state)
            IDLE: begin
                if (apb_psel_i && !apb_penable_i) begin
                    latch        = 1'b1;
                    wait_cnt_nxt = WC_W'(WAIT_STATES);
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb_psel_i) begin
                    state_nxt = IDLE;
                end else if (!apb_penable_i) begin
                    latch        = 1'b1;
                    wait_cnt_nxt = WC_W'(WAIT_STATES);
                end else if (wait_cnt != '0) begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end else begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (latch) begin
            addr_q  <= apb_paddr_i;
            wdata_q <= apb_pwdata_i;
            write_q <= apb_pwrite_i;
        end
    end

    // Decode only on the latched address so bus activity after SETUP is inert.
    assign hit_a   = (addr_q == ADDR_A);
    assign hit_b   = (addr_q == ADDR_B);
    assign hit_c   = (addr_q == ADDR_C);
    assign hit_clr = (addr_q == ADDR_CLR);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a      <= '0;
            cnt_b      <= '0;
            cnt_c      <= '0;
            cnt_bad    <= '0;
            last_wdata <= '0;
        end else if (commit && write_q) begin
            if (hit_a) begin
                cnt_a      <= sat_inc(cnt_a);
                last_wdata <= wdata_q;
            end else if (hit_b) begin
                cnt_b      <= sat_inc(cnt_b);
                last_wdata <= wdata_q;
            end else if (hit_c) begin
                cnt_c      <= sat_inc(cnt_c);
                last_wdata <= wdata_q;
            end else if (hit_clr) begin
                cnt_a   <= '0;
                cnt_b   <= '0;
                cnt_c   <= '0;
                cnt_bad <= '0;
            end else begin
                cnt_bad <= sat_inc(cnt_bad);
            end
        end
    end

    // Read data is gated by the completion pulse so the bus is quiet otherwise.
    always_comb begin
        apb_prdata_o = '0;
        if (commit && !write_q) begin
            if (hit_a) begin
                apb_prdata_o = 32'(cnt_a);
            end else if (hit_b) begin
                apb_prdata_o = 32'(cnt_b);
            end else if (hit_c) begin
                apb_prdata_o = 32'(cnt_c);
            end
        end
    end

    assign apb_pready_o   = commit;
    assign cnt_a_o        = cnt_a;
    assign cnt_b_o        = cnt_b;
    assign cnt_c_o        = cnt_c;
    assign bad_addr_cnt_o = cnt_bad;
    assign last_wdata_o   = last_wdata;

endmodule

// File: tb/tb_apb_event_sink.sv
// tb/tb_apb_event_sink.sv - scoreboard bench for apb_event_sink (one-wait and zero-wait/2-bit instances)
module tb_apb_event_sink;

    localparam logic [31:0] A   = 32'h0000_0000;
    localparam logic [31:0] B   = 32'h0000_0004;
    localparam logic [31:0] C   = 32'h0000_0008;
    localparam logic [31:0] CLR = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;

    logic        pready0, pready1;
    logic [31:0] prdata0, prdata1;
    logic [15:0] cnt_a0, cnt_b0, cnt_c0, bad0;
    logic [1:0]  cnt_a1, cnt_b1, cnt_c1, bad1;
    logic [31:0] last0, last1;

    always #5 clk = ~clk;

    apb_event_sink #(.WAIT_STATES(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset),
        .apb_psel_i(psel), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
        .apb_pready_o(pready0), .apb_prdata_o(prdata0),
        .cnt_a_o(cnt_a0), .cnt_b_o(cnt_b0), .cnt_c_o(cnt_c0),
        .bad_addr_cnt_o(bad0), .last_wdata_o(last0)
    );

    apb_event_sink #(.WAIT_STATES(0), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset),
        .apb_psel_i(psel), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
        .apb_pready_o(pready1), .apb_prdata_o(prdata1),
        .cnt_a_o(cnt_a1), .cnt_b_o(cnt_b1), .cnt_c_o(cnt_c1),
        .bad_addr_cnt_o(bad1), .last_wdata_o(last1)
    );

    typedef struct {
        bit          rd;
        logic [31:0] prdata;
        logic [31:0] a, b, c, bad, last;
    } exp_t;

    int unsigned m_cnt [2][3];
    int unsigned m_bad [2];
    logic [31:0] m_last [2];
    int unsigned m_max [2] = '{65535, 3};

    exp_t q0[$];
    exp_t q1[$];
    exp_t hold [2];
    bit   pend [2] = '{1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) m_cnt[d][i] = 0;
            m_bad[d]  = 0;
            m_last[d] = '0;
        end
    endtask

    task automatic model_xfer(input int d, input logic [31:0] addr, input bit wr,
                              input logic [31:0] data, output exp_t e);
        int idx;
        idx = (addr == A) ? 0 : (addr == B) ? 1 : (addr == C) ? 2 : -1;
        e.rd     = !wr;
        e.prdata = '0;
        if (!wr) begin
            if (idx >= 0) e.prdata = m_cnt[d][idx];
        end else if (idx >= 0) begin
            if (m_cnt[d][idx] < m_max[d]) m_cnt[d][idx]++;
            m_last[d] = data;
        end else if (addr == CLR) begin
            for (int i = 0; i < 3; i++) m_cnt[d][i] = 0;
            m_bad[d] = 0;
        end else if (m_bad[d] < m_max[d]) begin
            m_bad[d]++;
        end
        e.a    = m_cnt[d][0];
        e.b    = m_cnt[d][1];
        e.c    = m_cnt[d][2];
        e.bad  = m_bad[d];
        e.last = m_last[d];
    endtask

    task automatic mon_step(input int d, input logic pr, input logic [31:0] rd,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [31:0] bad, input logic [31:0] last);
        exp_t e;
        int   qs;
        if (pend[d]) begin
            check($sformatf("cnt_a_d%0d", d), a, hold[d].a);
            check($sformatf("cnt_b_d%0d", d), b, hold[d].b);
            check($sformatf("cnt_c_d%0d", d), c, hold[d].c);
            check($sformatf("bad_cnt_d%0d", d), bad, hold[d].bad);
            check($sformatf("last_wdata_d%0d", d), last, hold[d].last);
            pend[d] = 1'b0;
        end
        if (pr) begin
            qs = (d == 0) ? q0.size() : q1.size();
            checks++;
            if (qs == 0) begin
                errors++;
                $display("FAIL unexpected_pready_d%0d: got pready=1 expected 0 (no transfer outstanding)", d);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (e.rd) check($sformatf("prdata_d%0d", d), rd, e.prdata);
                hold[d] = e;
                pend[d] = 1'b1;
            end
        end else begin
            check($sformatf("prdata_idle_d%0d", d), rd, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (reset) pend[0] = 1'b0;
        else mon_step(0, pready0, prdata0, cnt_a0, cnt_b0, cnt_c0, bad0, last0);
    end

    always @(negedge clk) begin
        if (reset) pend[1] = 1'b0;
        else mon_step(1, pready1, prdata1, cnt_a1, cnt_b1, cnt_c1, bad1, last1);
    end

    task automatic check_state();
        check("state_cnt_a_d0", cnt_a0, m_cnt[0][0]);
        check("state_cnt_b_d0", cnt_b0, m_cnt[0][1]);
        check("state_cnt_c_d0", cnt_c0, m_cnt[0][2]);
        check("state_bad_d0", bad0, m_bad[0]);
        check("state_last_d0", last0, m_last[0]);
        check("state_cnt_a_d1", cnt_a1, m_cnt[1][0]);
        check("state_cnt_b_d1", cnt_b1, m_cnt[1][1]);
        check("state_cnt_c_d1", cnt_c1, m_cnt[1][2]);
        check("state_bad_d1", bad1, m_bad[1]);
        check("state_last_d1", last1, m_last[1]);
    endtask

    // Bus contents after SETUP are garbage on purpose; the completer must ignore them.
    task automatic scramble();
        paddr  = $urandom;
        pwdata = $urandom;
        pwrite = 1'($urandom_range(0, 1));
    endtask

    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] data);
        exp_t e0, e1;
        int   cyc, p0, p1;
        model_xfer(0, addr, wr, data, e0);
        q0.push_back(e0);
        model_xfer(1, addr, wr, data, e1);
        q1.push_back(e1);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        scramble();
        cyc = 2; p0 = 0; p1 = 0;
        while (p0 == 0 && cyc < 12) begin
            @(negedge clk);
            if (pready1) p1 = cyc;
            if (pready0) p0 = cyc;
            else begin
                @(posedge clk); #1;
                scramble();
                cyc++;
            end
        end
        check("pready_cycle_d0", p0, 3);
        check("pready_cycle_d1", p1, 2);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic abort_xfer();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = A; pwrite = 1'b1; pwdata = 32'hDEAD;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_pready_d0", pready0, 1'b0);
            check("abort_pready_d1", pready1, 1'b0);
        end
        check_state();
    endtask

    task automatic reset_mid_xfer();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = B; pwrite = 1'b1; pwdata = 32'hBEEF;
        @(posedge clk); #1;
        penable = 1'b1;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("rst_pready_d0", pready0, 1'b0);
            check("rst_pready_d1", pready1, 1'b0);
        end
        check_state();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        bit          wr;
        int          sel;

        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_pready_d0", pready0, 1'b0);
        check_state();

        xfer(A, 1'b1, 32'h1);
        idle(1);
        @(negedge clk);
        check("first_cnt_a_d0", cnt_a0, 32'h1);
        check("first_last_d0", last0, 32'h1);
        check("first_cnt_b_d0", cnt_b0, 32'h0);

        xfer(CLR, 1'b1, 32'h0);
        xfer(A, 1'b1, 32'h5);
        xfer(B, 1'b1, 32'h6);
        xfer(C, 1'b1, 32'h7);
        idle(1);
        @(negedge clk);
        check("b2b_last_d0", last0, 32'h7);
        check_state();

        xfer(CLR, 1'b1, 32'h0);
        repeat (3) xfer(B, 1'b1, $urandom);
        xfer(B, 1'b0, 32'h0);
        xfer(CLR, 1'b0, 32'h0);
        idle(1);

        xfer(32'h20, 1'b1, 32'h99);
        idle(1);
        @(negedge clk);
        check("bad_after_20_d0", bad0, 32'h1);
        xfer(CLR, 1'b1, 32'h0);
        idle(1);
        @(negedge clk);
        check_state();

        xfer(A, 1'b1, 32'h11);
        idle(1);
        abort_xfer();
        xfer(A, 1'b0, 32'h0);
        idle(1);
        reset_mid_xfer();

        repeat (5) xfer(A, 1'b1, $urandom);
        idle(1);
        @(negedge clk);
        check("sat_cnt_a_d1", cnt_a1, 32'h3);
        check("sat_cnt_a_d0", cnt_a0, 32'h5);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1, 2: addr = A;
                3, 4, 5: addr = B;
                6, 7, 8: addr = C;
                9:       addr = CLR;
                10:      addr = 32'h10;
                default: addr = $urandom;
            endcase
            wr = ($urandom_range(0, 3) != 0);
            xfer(addr, wr, $urandom);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 2));
        end

        idle(3);
        @(negedge clk);
        check_state();
        check("q0_drained", q0.size(), 32'h0);
        check("q1_drained", q1.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
